// File: rtl/team_02_imu_rx.sv
// Serial IMU frame receiver: synchronizes the pad strobe and data, samples mid-bit,
// and presents X/Y/Z through a valid/ready holding register with sticky overrun.
module team_02_imu_rx #(
  parameter int CLK_DIV = 4,
  parameter int AXIS_W  = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              imu_enable,
  input  logic              imu_ser_data,
  input  logic              out_ready,
  input  logic              clear_overrun,
  output logic              out_valid,
  output logic [AXIS_W-1:0] out_x,
  output logic [AXIS_W-1:0] out_y,
  output logic [AXIS_W-1:0] out_z,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);

  localparam int FRAME_W = 3 * AXIS_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] HALF_M1  = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0] FULL_M1  = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic               en_meta_q, en_meta_d, en_s_q, en_s_d, en_prev_q, en_prev_d;
  logic               sd_meta_q, sd_meta_d, sd_s_q, sd_s_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [AXIS_W-1:0]  out_x_q, out_x_d, out_y_q, out_y_d, out_z_q, out_z_d;
  logic               out_valid_q, out_valid_d, frame_err_q, frame_err_d;
  logic               overrun_q, overrun_d;
  logic               frame_done, xfer;

  always_comb begin
    state_d     = state_q;
    en_meta_d   = imu_enable;
    en_s_d      = en_meta_q;
    en_prev_d   = en_s_q;
    sd_meta_d   = imu_ser_data;
    sd_s_d      = sd_meta_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_z_d     = out_z_q;
    out_valid_d = out_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
    frame_done  = 1'b0;
    xfer        = out_valid_q & out_ready;

    case (state_q)
      IDLE: begin
        if (en_s_q && !en_prev_q) begin
          state_d = SHIFT;
          div_d   = HALF_M1;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      SHIFT: begin
        if (!en_s_q) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end else if (div_q == '0) begin
          shift_d = {shift_q[FRAME_W-2:0], sd_s_q};
          div_d   = FULL_M1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d    = DONE;
            frame_done = 1'b1;
          end
        end else begin
          div_d = div_q - DIV_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (clear_overrun) overrun_d = 1'b0;
    // The frame is committed on the edge that takes the last sample, so out_valid
    // is already high during the DONE cycle.
    if (frame_done) begin
      if (!out_valid_q || xfer) begin
        out_x_d     = shift_d[FRAME_W-1 -: AXIS_W];
        out_y_d     = shift_d[2*AXIS_W-1 -: AXIS_W];
        out_z_d     = shift_d[AXIS_W-1:0];
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= IDLE;
      en_meta_q   <= 1'b0;
      en_s_q      <= 1'b0;
      en_prev_q   <= 1'b0;
      sd_meta_q   <= 1'b0;
      sd_s_q      <= 1'b0;
      div_q       <= '0;
      cnt_q       <= '0;
      shift_q     <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_z_q     <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_meta_q   <= en_meta_d;
      en_s_q      <= en_s_d;
      en_prev_q   <= en_prev_d;
      sd_meta_q   <= sd_meta_d;
      sd_s_q      <= sd_s_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_z_q     <= out_z_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign busy      = (state_q == SHIFT);
  assign out_valid = out_valid_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_z     = out_z_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_team_02_imu_rx.sv
// Directed bench for team_02_imu_rx: nominal, backpressure, abort, simultaneous
// consume/load, mid-frame reset and held-enable scenarios.
module tb_team_02_imu_rx;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        imu_enable = 1'b0;
  logic        imu_ser_data = 1'b0;
  logic        out_ready = 1'b0;
  logic        clear_overrun = 1'b0;
  logic        out_valid, busy, frame_err, overrun;
  logic [15:0] out_x, out_y, out_z;

  int checks = 0;
  int errors = 0;

  team_02_imu_rx #(.CLK_DIV(4), .AXIS_W(16)) dut (
    .clk(clk), .nrst(nrst), .imu_enable(imu_enable), .imu_ser_data(imu_ser_data),
    .out_ready(out_ready), .clear_overrun(clear_overrun), .out_valid(out_valid),
    .out_x(out_x), .out_y(out_y), .out_z(out_z), .busy(busy),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Event monitor, sampled mid-cycle
  int          cyc = 0;
  int          busy_rise_cyc = 0, busy_rise_cnt = 0;
  int          ov_rise_cyc = 0, ov_rise_cnt = 0, ov_high_cnt = 0, ferr_cnt = 0;
  logic        busy_prev = 1'b0, ov_prev = 1'b0;
  logic [15:0] cap_x = '0, cap_y = '0, cap_z = '0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (busy && !busy_prev) begin
      busy_rise_cyc = cyc;
      busy_rise_cnt = busy_rise_cnt + 1;
    end
    if (out_valid && !ov_prev) begin
      ov_rise_cyc = cyc;
      ov_rise_cnt = ov_rise_cnt + 1;
      cap_x = out_x;
      cap_y = out_y;
      cap_z = out_z;
    end
    if (out_valid) ov_high_cnt = ov_high_cnt + 1;
    if (frame_err) ferr_cnt = ferr_cnt + 1;
    busy_prev = busy;
    ov_prev   = out_valid;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Called at a negedge; enable and the first bit go out together, 4 clk per bit
  task automatic send_frame(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                            input int nbits, input bit keep_en);
    logic [47:0] f;
    f = {x, y, z};
    imu_enable = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      imu_ser_data = f[47-i];
      repeat (4) @(negedge clk);
    end
    if (!keep_en) imu_enable = 1'b0;
    imu_ser_data = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int base_ferr, base_ov, base_busy, base_high;
  bit started;

  initial begin
    // Reset values
    idle_cycles(3);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_x", 64'(out_x), 64'd0);
    check_eq("rst_out_y", 64'(out_y), 64'd0);
    check_eq("rst_out_z", 64'(out_z), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_frame_err", 64'(frame_err), 64'd0);
    check_eq("rst_overrun", 64'(overrun), 64'd0);
    nrst = 1'b1;
    idle_cycles(3);

    // Nominal frame with consumer ready
    out_ready = 1'b1;
    base_high = ov_high_cnt;
    send_frame(16'h1234, 16'hABCD, 16'h0F0F, 48, 1'b0);
    idle_cycles(12);
    check_eq("nom_latency", 64'(ov_rise_cyc - busy_rise_cyc), 64'd190);
    check_eq("nom_x", 64'(cap_x), 64'h1234);
    check_eq("nom_y", 64'(cap_y), 64'hABCD);
    check_eq("nom_z", 64'(cap_z), 64'h0F0F);
    check_eq("nom_valid_cycles", 64'(ov_high_cnt - base_high), 64'd1);
    check_eq("nom_ferr", 64'(ferr_cnt), 64'd0);
    check_eq("nom_overrun", 64'(overrun), 64'd0);
    check_eq("nom_valid_after", 64'(out_valid), 64'd0);

    // Backpressure: second frame dropped, overrun set then cleared
    out_ready = 1'b0;
    send_frame(16'h5555, 16'h6666, 16'h7777, 48, 1'b0);
    idle_cycles(12);
    check_eq("bp_ovr_first", 64'(overrun), 64'd0);
    send_frame(16'hFFFF, 16'hFFFF, 16'hFFFF, 48, 1'b0);
    idle_cycles(12);
    check_eq("bp_valid", 64'(out_valid), 64'd1);
    check_eq("bp_x", 64'(out_x), 64'h5555);
    check_eq("bp_y", 64'(out_y), 64'h6666);
    check_eq("bp_z", 64'(out_z), 64'h7777);
    check_eq("bp_overrun", 64'(overrun), 64'd1);
    clear_overrun = 1'b1;
    idle_cycles(1);
    clear_overrun = 1'b0;
    check_eq("bp_overrun_clr", 64'(overrun), 64'd0);
    check_eq("bp_valid_held", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    idle_cycles(1);
    out_ready = 1'b0;
    check_eq("bp_drained", 64'(out_valid), 64'd0);

    // Simultaneous: ready only in the cycle that completes frame B
    send_frame(16'h1111, 16'h2222, 16'h3333, 48, 1'b0);
    idle_cycles(12);
    started = 1'b0;
    fork
      send_frame(16'h4444, 16'h5555, 16'h6666, 48, 1'b0);
      begin
        for (int i = 0; i < 50 && !started; i++) begin
          @(negedge clk);
          if (busy) started = 1'b1;
        end
        if (started) begin
          repeat (189) @(negedge clk);
          out_ready = 1'b1;
          @(negedge clk);
          out_ready = 1'b0;
        end
      end
    join
    check_eq("sim_started", 64'(started), 64'd1);
    idle_cycles(12);
    check_eq("sim_valid", 64'(out_valid), 64'd1);
    check_eq("sim_x", 64'(out_x), 64'h4444);
    check_eq("sim_y", 64'(out_y), 64'h5555);
    check_eq("sim_z", 64'(out_z), 64'h6666);
    check_eq("sim_overrun", 64'(overrun), 64'd0);

    // Abort after 20 bits; held frame must survive
    base_ferr = ferr_cnt;
    send_frame(16'hDEAD, 16'hBEEF, 16'hCAFE, 20, 1'b0);
    idle_cycles(12);
    check_eq("abort_ferr_cycles", 64'(ferr_cnt - base_ferr), 64'd1);
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_valid", 64'(out_valid), 64'd1);
    check_eq("abort_x", 64'(out_x), 64'h4444);
    check_eq("abort_z", 64'(out_z), 64'h6666);

    // Reset at bit 30
    base_ferr = ferr_cnt;
    send_frame(16'h0123, 16'h4567, 16'h89AB, 30, 1'b1);
    nrst = 1'b0;
    imu_enable = 1'b0;
    idle_cycles(2);
    check_eq("mrst_valid", 64'(out_valid), 64'd0);
    check_eq("mrst_x", 64'(out_x), 64'd0);
    check_eq("mrst_y", 64'(out_y), 64'd0);
    check_eq("mrst_z", 64'(out_z), 64'd0);
    check_eq("mrst_busy", 64'(busy), 64'd0);
    check_eq("mrst_overrun", 64'(overrun), 64'd0);
    nrst = 1'b1;
    idle_cycles(6);
    check_eq("mrst_no_ferr", 64'(ferr_cnt - base_ferr), 64'd0);
    out_ready = 1'b1;
    send_frame(16'hA5A5, 16'h5A5A, 16'hC3C3, 48, 1'b0);
    idle_cycles(12);
    check_eq("mrst_next_x", 64'(cap_x), 64'hA5A5);
    check_eq("mrst_next_y", 64'(cap_y), 64'h5A5A);
    check_eq("mrst_next_z", 64'(cap_z), 64'hC3C3);

    // Held enable: one frame only
    base_ov   = ov_rise_cnt;
    base_high = ov_high_cnt;
    base_busy = busy_rise_cnt;
    send_frame(16'h8001, 16'h7FFE, 16'h00FF, 48, 1'b1);
    idle_cycles(300);
    imu_enable = 1'b0;
    idle_cycles(12);
    check_eq("held_valid_events", 64'(ov_rise_cnt - base_ov), 64'd1);
    check_eq("held_valid_cycles", 64'(ov_high_cnt - base_high), 64'd1);
    check_eq("held_frames_started", 64'(busy_rise_cnt - base_busy), 64'd1);
    check_eq("held_x", 64'(cap_x), 64'h8001);
    check_eq("held_busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/team_02_imu_rx.md
TEAM_02_IMU_RX -- requirements
Module: team_02_imu_rx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per serial bit; even, minimum 2.
REQ-002 SHALL have parameter AXIS_W, default 16: bits per axis sample.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on rising edge.
REQ-004 SHALL have port nrst, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port imu_enable, input, 1: asynchronous frame strobe from the GPIO pad; high for the duration of a frame.
REQ-006 SHALL have port imu_ser_data, input, 1: asynchronous serial data from the GPIO pad, MSB first.
REQ-007 SHALL have port out_ready, input, 1: consumer accepts the sample.
REQ-008 SHALL have port clear_overrun, input, 1: clears the sticky overrun flag.
REQ-009 SHALL have port out_valid, output, 1: sample registers hold an unconsumed frame.
REQ-010 SHALL have ports out_x, out_y, out_z, output, AXIS_W each: the last completed frame.
REQ-011 SHALL have port busy, output, 1: a frame is in progress.
REQ-012 SHALL have port frame_err, output, 1: one-cycle pulse on an aborted frame.
REQ-013 SHALL have port overrun, output, 1: sticky flag set when a completed frame is dropped.

Function
REQ-014 SHALL pass imu_enable and imu_ser_data each through a 2-flop synchronizer; all logic below uses the synchronized versions (en_s, sd_s).
REQ-015 SHALL detect a frame start as en_s rising (en_s=1, previous en_s=0) while in IDLE; call the detection cycle T.
REQ-016 SHALL implement the FSM IDLE -> SHIFT -> DONE -> IDLE.
REQ-017 SHALL make busy = 1 exactly when the FSM is in SHIFT.
REQ-018 SHALL, in SHIFT, sample sd_s first at T + CLK_DIV/2, then every CLK_DIV cycles after that (mid-bit sampling).
REQ-019 SHALL shift each sample into a 3*AXIS_W shift register, MSB first.
REQ-020 SHALL interpret frame order as X[15:0], then Y[15:0], then Z[15:0].
REQ-021 SHALL use a bit counter of width ceil(log2(3*AXIS_W+1)); SHIFT->DONE when the counter reaches 3*AXIS_W after the final sample.
REQ-022 SHALL, in DONE (one cycle), load the frame into out_x/out_y/out_z, set out_valid, and go to IDLE.
REQ-023 SHALL, in SHIFT, abort if en_s falls before the final sample: pulse frame_err for one cycle, go to IDLE, leave the output registers and out_valid unchanged.
REQ-024 SHALL, when en_s stays high after frame completion, not start a new frame until en_s has gone low and risen again.
REQ-025 SHALL transfer a sample on any cycle where out_valid=1 and out_ready=1; out_valid clears the following cycle unless REQ-026 applies.
REQ-026 SHALL, when DONE coincides with a transfer, load the new frame and keep out_valid=1, without setting overrun.
REQ-027 SHALL, when DONE occurs while out_valid=1 and out_ready=0, drop the new frame, keep the old data, and set overrun.
REQ-028 SHALL clear overrun on clear_overrun=1; set takes priority if both occur in the same cycle.
REQ-029 SHALL hold out_x/out_y/out_z stable while out_valid=1 and no transfer occurs.

Reset
REQ-030 SHALL, on nrst=0 at a clk edge, force the FSM to IDLE and clear the synchronizers, shift register and counters.
REQ-031 SHALL reset outputs to: out_valid=0, out_x=out_y=out_z=0, busy=0, frame_err=0, overrun=0.
REQ-032 SHALL, on reset mid-frame, discard the partial frame with no frame_err pulse; while nrst=0, en_s rises are ignored.

Verification (CLK_DIV=4, AXIS_W=16)
REQ-033 Nominal: hold imu_enable high and send X=16'h1234, Y=16'hABCD, Z=16'h0F0F at 4 clk/bit, out_ready=1 -> busy from T+1, out_valid high one cycle at T+2+47*4+1 with matching data, no frame_err or overrun.
REQ-034 Backpressure: out_ready=0, send two frames (second 16'hFFFF x3) -> first frame held, overrun=1 after the second DONE; clear_overrun -> overrun=0.
REQ-035 Abort: drop imu_enable after 20 bits -> frame_err one-cycle pulse, busy=0, out_valid and data unchanged.
REQ-036 Simultaneous: out_ready asserted in the same cycle as the second frame's DONE -> first frame consumed, second frame loaded, out_valid stays 1, overrun=0.
REQ-037 Reset mid-frame: nrst=0 for 2 cycles at bit 30 -> all outputs at reset values; next full frame received correctly.
REQ-038 Held enable: keep imu_enable high 300 cycles past frame end -> exactly one out_valid and no second frame started.
